dmux4_rr_dispatcher: RTL and testbench
======================================

// Module: dmux4_rr_dispatcher
// PURPOSE
//   Sequencer for the 4-way demultiplexer path: accepts words from one
//   valid/ready source and steers each to exactly one of four consumers.
//   Target chosen round-robin over enabled channels, or forced by fixed_sel.
//   One-entry holding register; full throughput (1 word/cycle) when the
//   target consumer is ready.
// PARAMETERS
//   W      16   data width
//   CNT_W  16   width of sent_count
// PORTS
//   clock       in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-high
//   in_valid    in   1      source has a word
//   in_ready    out  1      dispatcher accepts the word this cycle
//   in_data     in   W      source word
//   mode        in   1      0 = round-robin, 1 = fixed
//   fixed_sel   in   2      target channel in fixed mode
//   en_mask     in   4      per-channel enable (RR eligibility)
//   out_valid   out  4      one-hot valid to consumers 0..3
//   out_ready   in   4      per-consumer ready
//   out_data    out  W      shared data bus to all consumers
//   cur_sel     out  2      channel of the held word
//   sent_count  out  CNT_W  words delivered since reset
// BEHAVIOUR
//   - States: IDLE (hold reg empty), HOLD (hold reg full, out_valid driven).
//   - Reset (async): state=IDLE, ptr=0, cur_sel=0, hold=0, sent_count=0,
//     out_valid=4'b0000, out_data=0; in_ready forced 0 while reset=1.
//   - Target pick at acceptance: mode=1 -> fixed_sel (en_mask ignored);
//     mode=0 -> first channel with en_mask set, scanning ptr,ptr+1,..
//     mod 4. mode/fixed_sel/en_mask sampled only at acceptance.
//   - can_pick = (mode==1) | (en_mask!=0).
//   - Latency: word accepted at edge N appears on out_valid/out_data in
//     the cycle after edge N (1 cycle); no combinational in->out path.
//   - IDLE: in_ready=can_pick. On in_valid&in_ready: hold<=in_data,
//     cur_sel<=pick, ->HOLD.
//   - HOLD: out_valid=1<<cur_sel, out_data=hold, others 0.
//     deliver = out_ready[cur_sel]. in_ready = deliver & can_pick.
//     deliver: sent_count++, ptr<=cur_sel+1 (3 wraps to 0).
//       +in_valid&in_ready: reload hold, new cur_sel picked using the
//       updated ptr (cur_sel+1), stay HOLD.  else ->IDLE.
//     no deliver: hold stable, out_valid stable (no retraction, no re-route
//     even if en_mask/mode change).
//   - out_ready on non-target channels ignored.
//   - sent_count wraps {CNT_W{1}} -> 0 silently.
//   - en_mask=0 in RR mode: in_ready=0, held word (if any) still delivered.
//   - Reset mid-HOLD: held word dropped, no delivery counted.
//   - out_data=0 in IDLE.
// STRUCTURE
//   - Shared header dmux4_defs.vh: `define ST_IDLE 1'b0, ST_HOLD 1'b1,
//     MODE_RR 1'b0, MODE_FIXED 1'b1.
//   - Sub-module rr_pick4: combinational, inputs mask[3:0], ptr[1:0],
//     outputs sel[1:0], any; rotate-priority encoder.
//   - out_valid one-hot from existing DMux4Way (in=state==HOLD, sel=cur_sel).
//   - Top: FSM, hold reg, ptr, counter.
// TESTING
//   1 RR, en_mask=4'b1111, all out_ready=1, in_valid=1 for 8 cycles,
//     data 1..8 -> channels 0,1,2,3,0,1,2,3; 1 word/cycle; sent_count=8.
//   2 RR, en_mask=4'b1010 -> deliveries alternate ch1,ch3,ch1,..;
//     ch0/ch2 out_valid never asserted.
//   3 fixed, fixed_sel=2, out_ready[2]=0 for 5 cycles, data=16'hBEEF ->
//     out_valid=4'b0100 and out_data=BEEF stable 5 cycles, in_ready=0;
//     toggle mode/en_mask meanwhile -> no change; release -> count+1.
//   4 RR, en_mask=0, in_valid=1 -> in_ready=0, out_valid=0, count=0.
//   5 reset asserted mid-HOLD (word 16'h1234 held) -> out_valid=0
//     immediately, state IDLE, sent_count=0, ptr=0 (next word to ch0).
//   6 CNT_W=4, 17 deliveries -> sent_count=1 after wrap.

Source files
------------

// File: rtl/dmux4_rr_dispatcher_pkg.sv
// Shared types and constants for the 4-way round-robin dispatcher.
package dmux4_rr_dispatcher_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Channel after c, wrapping 3 -> 0.
  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return c + 2'd1;
  endfunction

endpackage

// File: rtl/dmux4_rr_dispatcher_rr_pick4.sv
// Rotating-priority encoder: first set bit of i_mask scanning i_ptr, i_ptr+1, .. mod 4.
module rr_pick4
  import dmux4_rr_dispatcher_pkg::*;
(
  input  logic [3:0] i_mask,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_sel,
  output logic       o_any
);

  // Walk from the farthest offset back to i_ptr so the closest hit wins.
  always_comb begin
    logic [1:0] w_idx;
    w_idx = i_ptr;
    o_sel = i_ptr;
    o_any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_mask[w_idx]) begin
        o_sel = w_idx;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmux4_rr_dispatcher.sv
// Single-source to four-consumer dispatcher with one-entry holding register.
// state   | meaning
// IDLE    | holding register empty, out_valid low
// HOLD    | holding register full, out_valid one-hot on cur_sel
module dmux4_rr_dispatcher
  import dmux4_rr_dispatcher_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_in_data,
  input  logic             i_mode,
  input  logic [1:0]       i_fixed_sel,
  input  logic [3:0]       i_en_mask,
  output logic [3:0]       o_out_valid,
  input  logic [3:0]       i_out_ready,
  output logic [W-1:0]     o_out_data,
  output logic [1:0]       o_cur_sel,
  output logic [CNT_W-1:0] o_sent_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_hold;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic       w_can_pick;
  logic       w_deliver;
  logic       w_accept;
  logic [1:0] w_scan_ptr;
  logic [1:0] w_rr_sel;
  logic       w_rr_any;
  logic [1:0] w_pick;

  assign w_can_pick = (i_mode == MODE_FIXED) | (|i_en_mask);
  assign w_deliver  = (r_state == ST_HOLD) & i_out_ready[r_sel];
  assign w_accept   = i_in_valid & o_in_ready;

  // A back-to-back reload must scan from the pointer as it will be after this delivery.
  assign w_scan_ptr = (r_state == ST_HOLD) ? next_ch(r_sel) : r_ptr;

  rr_pick4 u_pick (
    .i_mask (i_en_mask),
    .i_ptr  (w_scan_ptr),
    .o_sel  (w_rr_sel),
    .o_any  (w_rr_any)
  );

  assign w_pick = (i_mode == MODE_FIXED) ? i_fixed_sel : w_rr_sel;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_deliver && !w_accept) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_out_valid = 4'b0000;
    o_out_data  = '0;
    o_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: o_in_ready = w_can_pick;
      ST_HOLD: begin
        o_out_valid = 4'b0001 << r_sel;
        o_out_data  = r_hold;
        o_in_ready  = w_deliver & w_can_pick;
      end
      default: ;
    endcase
    if (i_reset) o_in_ready = 1'b0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hold <= '0;
      r_sel  <= 2'd0;
      r_ptr  <= 2'd0;
      r_cnt  <= '0;
    end else begin
      if (w_deliver) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_ptr <= next_ch(r_sel);
      end
      if (w_accept) begin
        r_hold <= i_in_data;
        r_sel  <= w_pick;
      end
    end
  end

  assign o_cur_sel    = r_sel;
  assign o_sent_count = r_cnt;

endmodule

// File: tb/tb_dmux4_rr_dispatcher.sv
// Directed plus randomized bench for dmux4_rr_dispatcher against a transaction-level model.
module tb_dmux4_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [15:0] idata = '0;
  logic        mode = 1'b0;
  logic [1:0]  fsel = '0;
  logic [3:0]  mask = '0;
  logic [3:0]  oready = '0;

  logic        ir, ir4;
  logic [3:0]  ov, ov4;
  logic [15:0] od, od4;
  logic [1:0]  cs, cs4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model: at most one word in flight, a rotating pointer, a delivery tally.
  bit          m_held;
  logic [15:0] m_data;
  int          m_ch;
  int          m_ptr;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  dmux4_rr_dispatcher #(.W(16), .CNT_W(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_in_valid(iv), .o_in_ready(ir),
    .i_in_data(idata), .i_mode(mode), .i_fixed_sel(fsel), .i_en_mask(mask),
    .o_out_valid(ov), .i_out_ready(oready), .o_out_data(od),
    .o_cur_sel(cs), .o_sent_count(cnt)
  );

  dmux4_rr_dispatcher #(.W(16), .CNT_W(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_in_valid(iv), .o_in_ready(ir4),
    .i_in_data(idata), .i_mode(mode), .i_fixed_sel(fsel), .i_en_mask(mask),
    .o_out_valid(ov4), .i_out_ready(oready), .o_out_data(od4),
    .o_cur_sel(cs4), .o_sent_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic md, input logic [1:0] fs,
                                    input logic [3:0] mk, input int ptr);
    if (md) return int'(fs);
    for (int k = 0; k < 4; k++)
      if (mk[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_held = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Drive one cycle's inputs (at negedge), check all outputs, then advance the model over the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic md,
                      input logic [1:0] fs, input logic [3:0] mk, input logic [3:0] ordy);
    bit   can_pick, exp_rdy, deliver, accept;
    logic [3:0] exp_ov;
    iv = v; idata = d; mode = md; fsel = fs; mask = mk; oready = ordy;
    #1;
    can_pick = md || (mk != 4'b0000);
    deliver  = m_held && ordy[m_ch];
    exp_rdy  = can_pick && (!m_held || deliver);
    exp_ov   = m_held ? 4'(1 << m_ch) : 4'b0000;
    chk("out_valid", 32'(ov), 32'(exp_ov));
    chk("out_data", 32'(od), m_held ? 32'(m_data) : 32'd0);
    chk("in_ready", 32'(ir), 32'(exp_rdy));
    chk("cur_sel", 32'(cs), 32'(m_ch));
    chk("sent_count", 32'(cnt), 32'(m_cnt % 65536));
    chk("sent_count4", 32'(cnt4), 32'(m_cnt % 16));
    @(posedge clk);
    accept = v && exp_rdy;
    if (deliver) begin
      m_cnt++;
      m_ptr = (m_ch + 1) % 4;
    end
    if (accept) begin
      m_data = d;
      m_ch   = model_pick(md, fs, mk, m_ptr);
      m_held = 1;
    end else if (deliver) begin
      m_held = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_in_ready", 32'(ir), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_cur_sel", 32'(cs), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit seen02;
    model_reset();
    @(negedge clk);
    do_reset();

    // 4: RR with nothing enabled refuses input
    for (int i = 0; i < 3; i++) step(1'b1, 16'h00AA, 1'b0, 2'd0, 4'b0000, 4'b1111);
    chk("t4_count", 32'(cnt), 32'd0);
    chk("t4_valid", 32'(ov), 32'd0);

    // 1: full throughput across all four channels
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 2'd0, 4'b1111, 4'b1111);
    step(1'b0, 16'h0, 1'b0, 2'd0, 4'b1111, 4'b1111);
    chk("t1_count", 32'(cnt), 32'd8);

    // 2: only channels 1 and 3 enabled
    seen02 = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(16'h100 + i), 1'b0, 2'd0, 4'b1010, 4'b1111);
      seen02 |= ov[0] | ov[2];
    end
    step(1'b0, 16'h0, 1'b0, 2'd0, 4'b1010, 4'b1111);
    seen02 |= ov[0] | ov[2];
    chk("t2_ch02_quiet", 32'(seen02), 32'd0);

    // 3: fixed target stalled; mode/mask changes must not disturb the held word
    step(1'b1, 16'hBEEF, 1'b1, 2'd2, 4'b0000, 4'b1011);
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'h7777, 1'(i % 2), 2'(i), 4'(i * 3), 4'b1011);
    chk("t3_valid", 32'(ov), 32'h4);
    chk("t3_data", 32'(od), 32'hBEEF);
    step(1'b0, 16'h0, 1'b1, 2'd2, 4'b1111, 4'b0100);
    chk("t3_count", 32'(cnt), 32'd15);

    // 5: reset while a word is held
    step(1'b1, 16'h1234, 1'b1, 2'd1, 4'b1111, 4'b0000);
    step(1'b0, 16'h0, 1'b1, 2'd1, 4'b1111, 4'b0000);
    do_reset();
    step(1'b1, 16'h5555, 1'b0, 2'd3, 4'b1111, 4'b1111);
    chk("t5_next_ch", 32'(cs), 32'd0);
    chk("t5_next_valid", 32'(ov), 32'h1);

    // 6: wrap of the narrow counter after 17 deliveries
    step(1'b0, 16'h0, 1'b0, 2'd0, 4'b1111, 4'b1111);
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 16'(i), 1'b1, 2'(i), 4'b0000, 4'b1111);
    step(1'b0, 16'h0, 1'b1, 2'd0, 4'b0000, 4'b1111);
    chk("t6_count4", 32'(cnt4), 32'd1);
    chk("t6_count", 32'(cnt), 32'd17);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 2'($urandom),
           4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
